// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one backend memory/MMIO bus between the instruction-fetch requester
//   (read-only) and the memory-stage data requester. Single-cycle request
//   pulses are latched and serialized onto the bus. Data always wins over
//   fetch, and a transaction on the bus is never preempted. Fetch responses
//   killed by a pipeline flush are completed on the bus but not acked. A
//   watchdog raises a sticky bus_err when the backend hangs.
//
// Parameters
//   TIMEOUT : bus cycles without bus_ack before bus_err is set (0 = off)
//   CNT_W   : watchdog counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   i_req_pulse/i_addr       fetch read request
//   i_kill                   fetch flush, drops any outstanding fetch
//   i_ack/i_rdata            fetch completion and read data
//   d_req_pulse/d_rw/d_addr/d_wdata   data request (d_rw 1 = read)
//   d_ack/d_rdata            data completion and load data
//   bus_req/bus_rw/bus_addr/bus_wdata backend request, held until bus_ack
//   bus_ack/bus_rdata        backend completion and read data
//   bus_err                  sticky watchdog timeout flag
//
// Optional feature
//   ARB_PASSTHRU_EN : when defined, a data request arriving with the arbiter
//   fully idle is driven onto the bus in the same cycle. If the backend acks
//   in that cycle the request completes immediately without being latched.
//
// State | meaning
// IDLE  | bus free, no request on the bus
// BUS_D | data request owns the bus, waiting for bus_ack
// BUS_I | fetch request owns the bus, waiting for bus_ack

module mem_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_pulse,
  input  logic [31:0] i_addr,
  input  logic        i_kill,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req_pulse,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_req,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS_D = 2'd1, BUS_I = 2'd2} state_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t            state, state_n;
  logic              d_pend, d_pend_n, d_rw_q, d_rw_n;
  logic [31:0]       d_addr_q, d_addr_n, d_wdata_q, d_wdata_n;
  logic              i_pend, i_pend_n;
  logic [31:0]       i_addr_q, i_addr_n;
  logic              drop, drop_n;
  logic              bus_rw_q, bus_rw_n;
  logic [31:0]       bus_addr_q, bus_addr_n, bus_wdata_q, bus_wdata_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              err_q, err_n;
  logic              busy, load, pt_go, pt_done;

  always_comb begin
    busy = (state != IDLE);
`ifdef ARB_PASSTHRU_EN
    pt_go = (state == IDLE) && !d_pend && !i_pend && d_req_pulse;
`else
    pt_go = 1'b0;
`endif
    pt_done = pt_go && bus_ack;

    // Request latches. A pulse while the previous request is still
    // outstanding is ignored and leaves the captured fields alone.
    d_pend_n  = d_pend;
    d_rw_n    = d_rw_q;
    d_addr_n  = d_addr_q;
    d_wdata_n = d_wdata_q;
    if (d_req_pulse && !d_pend && !pt_done) begin
      d_pend_n  = 1'b1;
      d_rw_n    = d_rw;
      d_addr_n  = d_addr;
      d_wdata_n = d_wdata;
    end else if (state == BUS_D && bus_ack) begin
      d_pend_n = 1'b0;
    end

    // Once a fetch is dropped, i_pend no longer belongs to the bus
    // transaction, so a new fetch latched meanwhile survives its ack.
    i_pend_n = i_pend;
    i_addr_n = i_addr_q;
    if (i_kill) begin
      i_pend_n = 1'b0;
    end else if (i_req_pulse && !i_pend) begin
      i_pend_n = 1'b1;
      i_addr_n = i_addr;
    end else if (state == BUS_I && bus_ack && !drop) begin
      i_pend_n = 1'b0;
    end

    drop_n = drop;
    if (state == BUS_I) begin
      if (bus_ack)     drop_n = 1'b0;
      else if (i_kill) drop_n = 1'b1;
    end

    // Bus fields are copied into their own registers on entry so they stay
    // stable even if the fetch latch is refilled during a dropped fetch.
    state_n     = state;
    load        = 1'b0;
    bus_rw_n    = bus_rw_q;
    bus_addr_n  = bus_addr_q;
    bus_wdata_n = bus_wdata_q;
    if (!busy || bus_ack) begin
      if (d_pend_n) begin
        state_n     = BUS_D;
        load        = 1'b1;
        bus_rw_n    = d_rw_n;
        bus_addr_n  = d_addr_n;
        bus_wdata_n = d_rw_n ? 32'd0 : d_wdata_n;
      end else if (i_pend_n) begin
        state_n     = BUS_I;
        load        = 1'b1;
        bus_rw_n    = 1'b1;
        bus_addr_n  = i_addr_n;
        bus_wdata_n = 32'd0;
      end else begin
        state_n = IDLE;
      end
    end

    // Watchdog counts bus cycles without ack, saturating at TIMEOUT.
    cnt_n = cnt;
    err_n = err_q;
    if (load) begin
      cnt_n = '0;
    end else if (busy && !bus_ack) begin
      if (cnt != TO_LIM) cnt_n = cnt + 1'b1;
      if (TIMEOUT != 0 && cnt == TO_M1) err_n = 1'b1;
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_rw    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    d_ack     = 1'b0;
    d_rdata   = 32'd0;
    i_ack     = 1'b0;
    i_rdata   = 32'd0;
    if (rst) begin
      if (pt_go) begin
        bus_req   = 1'b1;
        bus_rw    = d_rw;
        bus_addr  = d_addr;
        bus_wdata = d_rw ? 32'd0 : d_wdata;
        d_ack     = bus_ack;
        if (bus_ack && d_rw) d_rdata = bus_rdata;
      end else if (busy) begin
        bus_req   = 1'b1;
        bus_rw    = bus_rw_q;
        bus_addr  = bus_addr_q;
        bus_wdata = bus_wdata_q;
        if (state == BUS_D) begin
          d_ack = bus_ack;
          if (bus_ack && bus_rw_q) d_rdata = bus_rdata;
        end else if (bus_ack && !drop && !i_kill) begin
          i_ack   = 1'b1;
          i_rdata = bus_rdata;
        end
      end
    end
    bus_err = err_q & rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      d_pend      <= 1'b0;
      d_rw_q      <= 1'b0;
      d_addr_q    <= 32'd0;
      d_wdata_q   <= 32'd0;
      i_pend      <= 1'b0;
      i_addr_q    <= 32'd0;
      drop        <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      cnt         <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      d_pend      <= d_pend_n;
      d_rw_q      <= d_rw_n;
      d_addr_q    <= d_addr_n;
      d_wdata_q   <= d_wdata_n;
      i_pend      <= i_pend_n;
      i_addr_q    <= i_addr_n;
      drop        <= drop_n;
      bus_rw_q    <= bus_rw_n;
      bus_addr_q  <= bus_addr_n;
      bus_wdata_q <= bus_wdata_n;
      cnt         <= cnt_n;
      err_q       <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.

module tb_mem_arbiter;
  localparam int TO = 8;
`ifdef ARB_PASSTHRU_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_pulse, i_kill, d_req_pulse, d_rw, bus_ack;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
  logic        i_ack, d_ack, bus_req, bus_rw, bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_pulse(i_req_pulse), .i_addr(i_addr), .i_kill(i_kill),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req_pulse(d_req_pulse), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  // reference model: who owns the bus (0 none, 1 data, 2 fetch) and queues of one
  int          m_owner;
  logic        m_cur_rw;
  logic [31:0] m_cur_addr, m_cur_wdata;
  logic        m_d_wait, m_d_rw;
  logic [31:0] m_d_addr, m_d_wdata;
  logic        m_i_wait;
  logic [31:0] m_i_addr;
  logic        m_dropped, m_err;
  int          m_wd;

  // backend: acks after be_lat bus cycles of the current transaction (-1 = never)
  int          be_cnt, be_lat, nxt_lat;
  logic [31:0] be_data, nxt_data;
  logic        pt_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cur_rw = 0; m_cur_addr = 0; m_cur_wdata = 0;
    m_d_wait = 0; m_d_rw = 0; m_d_addr = 0; m_d_wdata = 0;
    m_i_wait = 0; m_i_addr = 0; m_dropped = 0; m_err = 0; m_wd = 0;
    be_cnt = 0; be_lat = 0; be_data = 0;
  endtask

  task automatic clr_in();
    i_req_pulse = 0; i_kill = 0; d_req_pulse = 0;
  endtask

  // One clock cycle: inputs are already applied; drive backend, compare at
  // the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic        pt, acked;
    logic        e_req, e_rw, e_dack, e_iack;
    logic [31:0] e_addr, e_wdata, e_drd, e_ird;

    pt = PT && rst && m_owner == 0 && !m_d_wait && !m_i_wait && d_req_pulse;
    if (!rst)    bus_ack = 1'b0;
    else if (pt) bus_ack = pt_ack;
    else         bus_ack = (m_owner != 0) && (be_lat >= 0) && (be_cnt >= be_lat);
    if (pt) be_data = nxt_data;
    bus_rdata = bus_ack ? be_data : $urandom;

    e_req = 0; e_rw = 0; e_addr = 0; e_wdata = 0;
    e_dack = 0; e_drd = 0; e_iack = 0; e_ird = 0;
    if (rst && pt) begin
      e_req = 1; e_rw = d_rw; e_addr = d_addr; e_wdata = d_rw ? 32'd0 : d_wdata;
      e_dack = bus_ack; e_drd = (bus_ack && d_rw) ? bus_rdata : 32'd0;
    end else if (rst && m_owner != 0) begin
      e_req = 1; e_rw = m_cur_rw; e_addr = m_cur_addr;
      e_wdata = m_cur_rw ? 32'd0 : m_cur_wdata;
      e_dack = (m_owner == 1) && bus_ack;
      e_drd  = (e_dack && m_cur_rw) ? bus_rdata : 32'd0;
      e_iack = (m_owner == 2) && bus_ack && !m_dropped && !i_kill;
      e_ird  = e_iack ? bus_rdata : 32'd0;
    end

    @(negedge clk);
    chk("bus_req",   bus_req,   e_req);
    chk("bus_rw",    bus_rw,    e_rw);
    chk("bus_addr",  bus_addr,  e_addr);
    chk("bus_wdata", bus_wdata, e_wdata);
    chk("d_ack",     d_ack,     e_dack);
    chk("d_rdata",   d_rdata,   e_drd);
    chk("i_ack",     i_ack,     e_iack);
    chk("i_rdata",   i_rdata,   e_ird);
    chk("bus_err",   bus_err,   rst ? m_err : 1'b0);
    chk("ack_excl",  i_ack & d_ack, 1'b0);

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      acked = bus_ack && (m_owner != 0);
      if (d_req_pulse && !m_d_wait && !(pt && bus_ack)) begin
        m_d_wait = 1; m_d_rw = d_rw; m_d_addr = d_addr; m_d_wdata = d_wdata;
      end
      if (i_kill) begin
        m_i_wait = 0;
        if (m_owner == 2 && !acked) m_dropped = 1;
      end else if (i_req_pulse && !m_i_wait) begin
        m_i_wait = 1; m_i_addr = i_addr;
      end else if (acked && m_owner == 2 && !m_dropped) begin
        m_i_wait = 0;
      end
      if (acked) begin
        if (m_owner == 1) m_d_wait = 0;
        m_owner = 0; m_dropped = 0;
      end else if (m_owner != 0) begin
        if (m_wd < TO) m_wd++;
        if (TO != 0 && m_wd == TO) m_err = 1;
        be_cnt++;
      end
      if (m_owner == 0) begin
        if (m_d_wait) begin
          m_owner = 1; m_cur_rw = m_d_rw; m_cur_addr = m_d_addr; m_cur_wdata = m_d_wdata;
        end else if (m_i_wait) begin
          m_owner = 2; m_cur_rw = 1; m_cur_addr = m_i_addr; m_cur_wdata = 0;
        end
        if (m_owner != 0) begin
          m_wd = 0; be_cnt = 0; be_lat = nxt_lat; be_data = nxt_data;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 0; clr_in();
    d_rw = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    bus_ack = 0; bus_rdata = 0; pt_ack = 0;
    nxt_lat = 0; nxt_data = 0;
    model_reset();

    // reset held with d_req_pulse toggling
    for (int k = 0; k < 3; k++) begin
      d_req_pulse = k[0]; d_rw = 1; d_addr = 32'h10 + k;
      cycle();
    end
    clr_in(); rst = 1;
    cycle();

    // data read, backend acks two cycles after bus_req
    nxt_lat = 2; nxt_data = 32'hDEADBEEF;
    d_req_pulse = 1; d_rw = 1; d_addr = 32'h100; d_wdata = 32'h1234;
    cycle(); clr_in();
    repeat (4) cycle();

    // collision: data write and fetch in the same cycle, 1-cycle backend
    nxt_lat = 0; nxt_data = 32'h0BADF00D;
    i_req_pulse = 1; i_addr = 32'h40;
    d_req_pulse = 1; d_rw = 0; d_addr = 32'h200; d_wdata = 32'h55;
    cycle(); clr_in();
    repeat (4) cycle();

    // kill one cycle before bus_ack, then a new fetch in the ack cycle
    nxt_lat = 3; nxt_data = 32'hAAAA0080;
    i_req_pulse = 1; i_addr = 32'h80;
    cycle(); clr_in();
    repeat (2) cycle();
    i_kill = 1;
    cycle(); clr_in();
    nxt_lat = 1; nxt_data = 32'hBBBB0084;
    i_req_pulse = 1; i_addr = 32'h84;
    cycle(); clr_in();
    repeat (4) cycle();

    // random traffic, backend latency 0..4
    for (int n = 0; n < 600; n++) begin
      nxt_lat  = $urandom_range(0, 4);
      nxt_data = $urandom;
      d_req_pulse = ($urandom_range(0, 3) == 0);
      d_rw        = $urandom_range(0, 1);
      d_addr      = $urandom;
      d_wdata     = $urandom;
      i_req_pulse = ($urandom_range(0, 2) == 0);
      i_addr      = $urandom;
      i_kill      = ($urandom_range(0, 11) == 0);
      rst         = !(n == 300);
      cycle();
    end
    clr_in(); rst = 1;
    repeat (6) cycle();

`ifdef ARB_PASSTHRU_EN
    // passthrough with a combinational-ack backend
    pt_ack = 1; nxt_data = 32'hCAFE0300;
    d_req_pulse = 1; d_rw = 1; d_addr = 32'h300;
    cycle(); clr_in(); pt_ack = 0;
    cycle();
`endif

    // watchdog: backend never acks, then a late ack
    nxt_lat = -1; nxt_data = 32'h600DD00D;
    d_req_pulse = 1; d_rw = 1; d_addr = 32'h500;
    cycle(); clr_in();
    repeat (12) cycle();
    chk("wd_err_set", bus_err, 1'b1);
    be_lat = 0;
    cycle();
    repeat (3) cycle();
    chk("wd_err_sticky", bus_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
